// File: rtl/pcie_axi_master_wr.sv
// Write-DMA initiator: turns one (address, beat count) command into AXI4 INCR write bursts
// fed from a local 256-bit stream, split at MAX_BURST beats and 4KB pages, with B-response checking.
module pcie_axi_master_wr #(
  parameter int unsigned DATA_W    = 256,
  parameter int unsigned ADDR_W    = 64,
  parameter int unsigned MAX_BURST = 16,
  parameter logic [7:0]  AXI_ID    = 8'h01
) (
  input  logic                axiclk,
  input  logic                in_user,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [10:0]         cmd_beats,
  input  logic [DATA_W-1:0]   s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic                done,
  output logic                err,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [7:0]          m_awid,
  output logic [7:0]          m_awlen,
  output logic [2:0]          m_awsize,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wdata_par,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic [DATA_W/64-1:0] m_wstrb_par,
  output logic                m_wlast,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic [7:0]          m_bid,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned SPAR_W = DATA_W / 64;
  localparam int unsigned CNT_W  = 11;

  typedef enum logic [2:0] {
    S_IDLE, S_CALC, S_AW, S_WDATA, S_WRESP, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [7:0]         burst_q, burst_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [ADDR_W-1:0]  awaddr_q, awaddr_d;
  logic [7:0]         awlen_q, awlen_d;
  logic               cmd_ready_q, done_q, awvalid_q, bready_q;

  logic [CNT_W-1:0]   room_c, burst_c;
  logic               in_wdata_c, w_fire_c, last_c;
  logic               unused_addr_c;

  assign unused_addr_c = ^cmd_addr[4:0];

  // Burst size: limited by remaining beats, MAX_BURST and beats left in the current 4KB page
  always_comb begin
    room_c  = 11'(128) - 11'(addr_q[11:5]);
    burst_c = rem_q;
    if (11'(MAX_BURST) < burst_c) burst_c = 11'(MAX_BURST);
    if (room_c < burst_c)         burst_c = room_c;
  end

  assign in_wdata_c = (state_q == S_WDATA);
  assign w_fire_c   = in_wdata_c && s_valid && m_wready;
  assign last_c     = (cnt_q == (burst_q - 8'd1));

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    burst_d  = burst_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    awaddr_d = awaddr_q;
    awlen_d  = awlen_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_d = {cmd_addr[ADDR_W-1:5], 5'b0};
          rem_d  = cmd_beats;
          if (cmd_beats == 11'd0) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            err_d   = 1'b0;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        burst_d  = 8'(burst_c);
        awlen_d  = 8'(burst_c - 11'd1);
        awaddr_d = addr_q;
        state_d  = S_AW;
      end
      S_AW: begin
        if (awvalid_q && m_awready) begin
          cnt_d   = 8'd0;
          state_d = S_WDATA;
        end
      end
      S_WDATA: begin
        if (w_fire_c) begin
          cnt_d = cnt_q + 8'd1;
          if (last_c) state_d = S_WRESP;
        end
      end
      S_WRESP: begin
        // Errors are sticky but never abort, so the input stream stays beat-aligned
        if (m_bvalid && bready_q) begin
          if ((m_bresp != 2'b00) || (m_bid != AXI_ID)) err_d = 1'b1;
          rem_d   = rem_q - 11'(burst_q);
          addr_d  = addr_q + (ADDR_W'(burst_q) << 5);
          state_d = (rem_d == 11'd0) ? S_DONE : S_CALC;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge axiclk or negedge in_user) begin
    if (!in_user) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      burst_q     <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      awaddr_q    <= '0;
      awlen_q     <= '0;
      cmd_ready_q <= 1'b0;
      done_q      <= 1'b0;
      awvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      burst_q     <= burst_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      awaddr_q    <= awaddr_d;
      awlen_q     <= awlen_d;
      cmd_ready_q <= (state_d == S_IDLE);
      done_q      <= (state_d == S_DONE);
      awvalid_q   <= (state_d == S_AW);
      bready_q    <= (state_d == S_WRESP);
    end
  end

  // Odd parity per byte: parity bit makes the 9-bit group have an odd number of ones
  always_comb begin
    m_wdata_par = '0;
    m_wstrb_par = '0;
    for (int i = 0; i < int'(STRB_W); i++) m_wdata_par[i] = ~^s_data[8*i +: 8];
    for (int i = 0; i < int'(SPAR_W); i++) m_wstrb_par[i] = ~^m_wstrb[8*i +: 8];
  end

  assign cmd_ready = cmd_ready_q;
  assign done      = done_q;
  assign err       = err_q;
  assign m_awaddr  = awaddr_q;
  assign m_awid    = AXI_ID;
  assign m_awlen   = awlen_q;
  assign m_awsize  = 3'd5;
  assign m_awvalid = awvalid_q;
  assign m_wdata   = s_data;
  assign m_wstrb   = '1;
  assign m_wlast   = in_wdata_c && last_c;
  assign m_wvalid  = in_wdata_c && s_valid;
  assign s_ready   = in_wdata_c && m_wready;
  assign m_bready  = bready_q;

endmodule

// File: tb/tb_pcie_axi_master_wr.sv
// Directed bench for pcie_axi_master_wr: AXI slave responder, stream source and beat/burst logger.
module tb_pcie_axi_master_wr;

  logic         axiclk = 1'b0;
  logic         in_user = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [63:0]  cmd_addr = '0;
  logic [10:0]  cmd_beats = '0;
  logic [255:0] s_data;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic         done, err;
  logic [63:0]  m_awaddr;
  logic [7:0]   m_awid, m_awlen;
  logic [2:0]   m_awsize;
  logic         m_awvalid;
  logic         m_awready = 1'b0;
  logic [255:0] m_wdata;
  logic [31:0]  m_wdata_par, m_wstrb;
  logic [3:0]   m_wstrb_par;
  logic         m_wlast, m_wvalid;
  logic         m_wready = 1'b0;
  logic [7:0]   m_bid = 8'h01;
  logic [1:0]   m_bresp = 2'b00;
  logic         m_bvalid = 1'b0;
  logic         m_bready;

  always #5 axiclk = ~axiclk;

  pcie_axi_master_wr dut (
    .axiclk(axiclk), .in_user(in_user),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .done(done), .err(err),
    .m_awaddr(m_awaddr), .m_awid(m_awid), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wdata_par(m_wdata_par), .m_wstrb(m_wstrb), .m_wstrb_par(m_wstrb_par),
    .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [31:0] pat32(input int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A_0000;
  endfunction

  int src_idx = 0;
  assign s_data = {8{pat32(src_idx)}};

  // Responder knobs, written only by the stimulus block
  logic       gaps = 1'b0;
  logic       hold_w = 1'b0;
  logic [1:0] bresp_tab [64];
  logic [7:0] bid_tab [64];

  // Logger state, written only by the negedge monitor
  logic [63:0]  aw_addr_log [$];
  logic [7:0]   aw_len_log [$];
  logic [255:0] w_data_log [$];
  logic         w_last_log [$];
  int cyc = 0, done_cnt = 0, done_cyc = 0, wlast_cnt = 0, aw_beats = 0;
  int early_w = 0, aw_unstable = 0, par_bad = 0, sr_bad = 0;
  logic done_err = 1'b0, aw_wait = 1'b0, w_fire = 1'b0, b_fire = 1'b0;
  logic [63:0] aw_prev_a = '0;
  logic [7:0]  aw_prev_l = '0;
  int b_done = 0;

  always @(negedge axiclk) begin
    cyc++;
    if (done) begin done_cnt++; done_err = err; done_cyc = cyc; end
    if (m_awvalid) begin
      if (aw_wait && (m_awaddr !== aw_prev_a || m_awlen !== aw_prev_l)) aw_unstable++;
      aw_prev_a = m_awaddr;
      aw_prev_l = m_awlen;
      aw_wait   = !m_awready;
      if (m_awready) begin
        aw_addr_log.push_back(m_awaddr);
        aw_len_log.push_back(m_awlen);
        aw_beats += int'(m_awlen) + 1;
      end
    end else aw_wait = 1'b0;
    if (m_wvalid && (s_ready !== m_wready)) sr_bad++;
    if (m_wvalid && m_wready) begin
      if (w_data_log.size() >= aw_beats) early_w++;
      w_data_log.push_back(m_wdata);
      w_last_log.push_back(m_wlast);
      if (m_wlast) wlast_cnt++;
      for (int i = 0; i < 32; i++)
        if (m_wdata_par[i] !== (($countones(m_wdata[8*i +: 8]) % 2) == 0)) par_bad++;
      for (int i = 0; i < 4; i++)
        if (m_wstrb_par[i] !== (($countones(m_wstrb[8*i +: 8]) % 2) == 0)) par_bad++;
    end
    w_fire = s_valid && s_ready;
    b_fire = m_bvalid && m_bready;
  end

  // Slave/source driver: updates 1 time unit after each rising edge
  always @(posedge axiclk) begin
    #1;
    if (w_fire) src_idx++;
    if (b_fire) begin m_bvalid = 1'b0; b_done++; end
    if (!m_bvalid && (wlast_cnt > b_done)) begin
      m_bvalid = 1'b1;
      m_bid    = bid_tab[b_done];
      m_bresp  = bresp_tab[b_done];
    end
    s_valid   = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
    m_awready = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
    m_wready  = hold_w ? 1'b0 : (gaps ? 1'($urandom_range(0, 1)) : 1'b1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  int acc_cyc = 0;

  task automatic send_cmd(input logic [63:0] a, input logic [10:0] n);
    logic seen;
    seen = 1'b0;
    @(posedge axiclk); #1;
    cmd_valid = 1'b1; cmd_addr = a; cmd_beats = n;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge axiclk);
      seen = cmd_ready;
    end
    acc_cyc = cyc;
    chk("cmd_accept", 64'(seen), 64'd1);
    @(posedge axiclk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int start);
    for (int i = 0; i < 3000 && done_cnt == start; i++) @(negedge axiclk);
    @(negedge axiclk);
    chk($sformatf("%s done_pulse", tag), 64'(done_cnt), 64'(start + 1));
  endtask

  // Burst list given as (address, beat count) triples; wlast must mark each burst's final beat
  task automatic check_run(input string tag, input int n_aw,
                           input logic [63:0] a0, input int n0,
                           input logic [63:0] a1, input int n1,
                           input logic [63:0] a2, input int n2,
                           input int beats, input logic exp_err,
                           input int aw_base, input int w_base);
    logic [63:0] ea [3];
    int en [3];
    int bad, cum, b, idx;
    ea = '{a0, a1, a2};
    en = '{n0, n1, n2};
    chk($sformatf("%s aw_count", tag), 64'(aw_addr_log.size() - aw_base), 64'(n_aw));
    for (int i = 0; i < n_aw; i++) begin
      if (aw_base + i < aw_addr_log.size()) begin
        chk($sformatf("%s aw%0d_addr", tag, i), aw_addr_log[aw_base + i], ea[i]);
        chk($sformatf("%s aw%0d_len", tag, i), 64'(aw_len_log[aw_base + i]), 64'(en[i] - 1));
      end
    end
    chk($sformatf("%s beat_count", tag), 64'(w_data_log.size() - w_base), 64'(beats));
    bad = 0; b = 0; cum = en[0];
    for (int j = 0; j < beats; j++) begin
      idx = w_base + j;
      if (idx >= w_data_log.size()) bad++;
      else begin
        if (w_data_log[idx] !== {8{pat32(idx)}}) bad++;
        if (w_last_log[idx] !== (j == cum - 1)) bad++;
      end
      if (j == cum - 1 && b < 2) begin b++; cum += en[b]; end
    end
    chk($sformatf("%s data_wlast_bad", tag), 64'(bad), 64'd0);
    chk($sformatf("%s err", tag), 64'(done_err), 64'(exp_err));
  endtask

  int awb, wb, d0, b0;
  logic seen_w;

  initial begin
    for (int i = 0; i < 64; i++) begin bresp_tab[i] = 2'b00; bid_tab[i] = 8'h01; end

    // Reset values
    repeat (3) @(negedge axiclk);
    chk("rst cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst err", 64'(err), 64'd0);
    chk("rst awvalid", 64'(m_awvalid), 64'd0);
    chk("rst wvalid", 64'(m_wvalid), 64'd0);
    chk("rst s_ready", 64'(s_ready), 64'd0);
    chk("rst bready", 64'(m_bready), 64'd0);
    chk("rst awaddr", m_awaddr, 64'd0);
    chk("rst awlen", 64'(m_awlen), 64'd0);
    chk("awsize", 64'(m_awsize), 64'd5);
    chk("awid", 64'(m_awid), 64'h01);
    chk("wstrb", 64'(m_wstrb), 64'hFFFF_FFFF);
    chk("wstrb_par", 64'(m_wstrb_par), 64'hF);
    @(posedge axiclk); #1;
    in_user = 1'b1;
    @(negedge axiclk);
    chk("rel cmd_ready_early", 64'(cmd_ready), 64'd0);
    @(negedge axiclk);
    chk("rel cmd_ready", 64'(cmd_ready), 64'd1);

    // 1: single aligned burst
    awb = aw_addr_log.size(); wb = w_data_log.size(); d0 = done_cnt;
    send_cmd(64'h1000, 11'd4); wait_done("t1", d0);
    check_run("t1", 1, 64'h1000, 4, 64'h0, 0, 64'h0, 0, 4, 1'b0, awb, wb);

    // 2: split at 4KB page
    awb = aw_addr_log.size(); wb = w_data_log.size(); d0 = done_cnt;
    send_cmd(64'h0FC0, 11'd4); wait_done("t2", d0);
    check_run("t2", 2, 64'h0FC0, 2, 64'h1000, 2, 64'h0, 0, 4, 1'b0, awb, wb);

    // 3: split at MAX_BURST; low address bits ignored
    awb = aw_addr_log.size(); wb = w_data_log.size(); d0 = done_cnt;
    send_cmd(64'h001F, 11'd40); wait_done("t3", d0);
    check_run("t3", 3, 64'h000, 16, 64'h200, 16, 64'h400, 8, 40, 1'b0, awb, wb);

    // 4: random handshake gaps
    gaps = 1'b1;
    awb = aw_addr_log.size(); wb = w_data_log.size(); d0 = done_cnt;
    send_cmd(64'h2000, 11'd20); wait_done("t4", d0);
    check_run("t4", 2, 64'h2000, 16, 64'h2200, 4, 64'h0, 0, 20, 1'b0, awb, wb);
    gaps = 1'b0;

    // 5a: SLVERR on first burst, second burst still issued
    b0 = b_done; bresp_tab[b0] = 2'b10;
    awb = aw_addr_log.size(); wb = w_data_log.size(); d0 = done_cnt;
    send_cmd(64'h3000, 11'd32); wait_done("t5a", d0);
    check_run("t5a", 2, 64'h3000, 16, 64'h3200, 16, 64'h0, 0, 32, 1'b1, awb, wb);

    // 5b: bid mismatch
    b0 = b_done; bid_tab[b0] = 8'h02;
    awb = aw_addr_log.size(); wb = w_data_log.size(); d0 = done_cnt;
    send_cmd(64'h4000, 11'd4); wait_done("t5b", d0);
    check_run("t5b", 1, 64'h4000, 4, 64'h0, 0, 64'h0, 0, 4, 1'b1, awb, wb);

    // clean command after errors clears sticky err; 4-beat page tail then 2 beats
    awb = aw_addr_log.size(); wb = w_data_log.size(); d0 = done_cnt;
    send_cmd(64'h4F80, 11'd6); wait_done("t7", d0);
    check_run("t7", 2, 64'h4F80, 4, 64'h5000, 2, 64'h0, 0, 6, 1'b0, awb, wb);

    // 6a: zero-beat command
    awb = aw_addr_log.size(); wb = w_data_log.size(); d0 = done_cnt;
    send_cmd(64'h6000, 11'd0); wait_done("t6a", d0);
    check_run("t6a", 0, 64'h0, 0, 64'h0, 0, 64'h0, 0, 0, 1'b1, awb, wb);
    chk("t6a latency_ok", 64'((done_cyc - acc_cyc >= 1) && (done_cyc - acc_cyc <= 2)), 64'd1);

    // 6b: reset while in W_DATA
    hold_w = 1'b1;
    d0 = done_cnt;
    send_cmd(64'h7000, 11'd8);
    seen_w = 1'b0;
    for (int i = 0; i < 100 && !seen_w; i++) begin
      @(negedge axiclk);
      seen_w = m_wvalid;
    end
    chk("t6b reached_wdata", 64'(seen_w), 64'd1);
    in_user = 1'b0;
    #1;
    chk("t6b wvalid", 64'(m_wvalid), 64'd0);
    chk("t6b awvalid", 64'(m_awvalid), 64'd0);
    chk("t6b bready", 64'(m_bready), 64'd0);
    chk("t6b cmd_ready", 64'(cmd_ready), 64'd0);
    chk("t6b done", 64'(done), 64'd0);
    @(posedge axiclk); #1;
    in_user = 1'b1; hold_w = 1'b0;
    repeat (2) @(negedge axiclk);
    chk("t6b cmd_ready_after", 64'(cmd_ready), 64'd1);
    chk("t6b no_done", 64'(done_cnt), 64'(d0));

    // Protocol-level invariants over the whole run
    chk("early_w", 64'(early_w), 64'd0);
    chk("aw_unstable", 64'(aw_unstable), 64'd0);
    chk("parity_bad", 64'(par_bad), 64'd0);
    chk("s_ready_bad", 64'(sr_bad), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
